bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 96 +++++++++
 tb/tb_bit_serializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter. It loads a WIDTH-bit word on a valid/ready handshake
// and sends it out one bit per clock, chaining back-to-back words with no gap.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PEN_CNT  = CNT_W'(WIDTH - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift_reg;

  logic             last_bit;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shift_rest;

  // bit_cnt is the index of the bit currently shown on dout.
  assign last_bit  = (state == SHIFT) && (bit_cnt == LAST_CNT);
  assign din_ready = (state == IDLE) || last_bit;
  assign accept    = din_valid && din_ready;

  // The first bit goes straight to dout on the load edge, so the register keeps
  // only the bits that are still to be sent.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign first_bit  = din[WIDTH-1];
      assign load_rest  = {din[WIDTH-2:0], 1'b0};
      assign next_bit   = shift_reg[WIDTH-1];
      assign shift_rest = {shift_reg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign first_bit  = din[0];
      assign load_rest  = {1'b0, din[WIDTH-1:1]};
      assign next_bit   = shift_reg[0];
      assign shift_rest = {1'b0, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  // NOTE: state registers use non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      word_done  <= 1'b0;
    end else if (accept) begin
      // An accept on the last-bit edge chains the new word with no idle gap.
      state      <= SHIFT;
      bit_cnt    <= '0;
      shift_reg  <= load_rest;
      dout       <= first_bit;
      dout_valid <= 1'b1;
      busy       <= 1'b1;
      word_done  <= 1'b0;
    end else if (state == SHIFT) begin
      if (last_bit) begin
        state      <= IDLE;
        bit_cnt    <= '0;
        dout       <= 1'b0;
        dout_valid <= 1'b0;
        busy       <= 1'b0;
        word_done  <= 1'b0;
      end else begin
        bit_cnt    <= bit_cnt + 1'b1;
        shift_reg  <= shift_rest;
        dout       <= next_bit;
        word_done  <= (bit_cnt == PEN_CNT);
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: one MSB-first and one LSB-first instance, checked every
// cycle against a queue-based stream model, plus literal checks on captured streams.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din [2];
  logic       dv [2];
  logic       rdy_w [2];
  logic       dout_w [2];
  logic       val_w [2];
  logic       busy_w [2];
  logic       done_w [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk       (clk),
    .rst       (rst),
    .din       (din[0]),
    .din_valid (dv[0]),
    .din_ready (rdy_w[0]),
    .dout      (dout_w[0]),
    .dout_valid(val_w[0]),
    .busy      (busy_w[0]),
    .word_done (done_w[0])
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk       (clk),
    .rst       (rst),
    .din       (din[1]),
    .din_valid (dv[1]),
    .din_ready (rdy_w[1]),
    .dout      (dout_w[1]),
    .dout_valid(val_w[1]),
    .busy      (busy_w[1]),
    .word_done (done_w[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the bits still owed to the stream, in transmit order. A word is taken
  // only when nothing is owed; each edge shows the next owed bit.
  bit   exp_q [2][$];
  logic m_dout [2]  = '{1'b0, 1'b0};
  logic m_valid [2] = '{1'b0, 1'b0};
  logic m_done [2]  = '{1'b0, 1'b0};

  task automatic model_step(input int k, input bit msb_first);
    bit b;
    if (dv[k] && exp_q[k].size() == 0)
      for (int i = 0; i < 8; i++)
        exp_q[k].push_back(msb_first ? din[k][7-i] : din[k][i]);
    if (exp_q[k].size() != 0) begin
      b = exp_q[k].pop_front();
      m_dout[k]  <= b;
      m_valid[k] <= 1'b1;
      m_done[k]  <= (exp_q[k].size() == 0);
    end else begin
      m_dout[k]  <= 1'b0;
      m_valid[k] <= 1'b0;
      m_done[k]  <= 1'b0;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        exp_q[k].delete();
        m_dout[k]  <= 1'b0;
        m_valid[k] <= 1'b0;
        m_done[k]  <= 1'b0;
      end
    end else begin
      model_step(0, 1'b1);
      model_step(1, 1'b0);
    end
  end

  // Per-cycle comparison and stream capture, both away from the rising edge.
  bit rec [2][$];
  int done_pos [2][$];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dout[%0d]", k), 32'(dout_w[k]), 32'(m_dout[k]));
      check($sformatf("dout_valid[%0d]", k), 32'(val_w[k]), 32'(m_valid[k]));
      check($sformatf("busy[%0d]", k), 32'(busy_w[k]), 32'(m_valid[k]));
      check($sformatf("word_done[%0d]", k), 32'(done_w[k]), 32'(m_done[k]));
      check($sformatf("din_ready[%0d]", k), 32'(rdy_w[k]), 32'(exp_q[k].size() == 0));
      if (val_w[k] === 1'b1) rec[k].push_back(dout_w[k]);
      if (done_w[k] === 1'b1) done_pos[k].push_back(rec[k].size());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    for (int k = 0; k < 2; k++) begin
      rec[k].delete();
      done_pos[k].delete();
    end
  endtask

  function automatic logic [31:0] rec_vec(input int k);
    logic [31:0] v = '0;
    for (int i = 0; i < rec[k].size(); i++) v = {v[30:0], rec[k][i]};
    return v;
  endfunction

  int rdy_cnt;
  int hits[$];
  int exp_hits[4] = '{6, 8, 10, 15};

  initial begin
    din[0] = 8'h00; din[1] = 8'h00;
    dv[0]  = 1'b0;  dv[1]  = 1'b0;
    #1 rst = 1'b0;
    repeat (3) tick();
    check("rst_dout", 32'(dout_w[0]), 32'd0);
    check("rst_valid", 32'(val_w[0]), 32'd0);
    check("rst_busy", 32'(busy_w[0]), 32'd0);
    check("rst_ready", 32'(rdy_w[0]), 32'd1);

    // Single word 8'hAA, offered during reset and taken on the first edge after release.
    clear_rec();
    din[0] = 8'hAA; dv[0] = 1'b1;
    rst = 1'b1;
    tick();
    dv[0] = 1'b0;
    repeat (11) tick();
    check("aa_count", rec[0].size(), 32'd8);
    check("aa_stream", rec_vec(0), 32'h0000_00AA);
    check("aa_done_count", done_pos[0].size(), 32'd1);
    if (done_pos[0].size() > 0) check("aa_done_pos", done_pos[0][0], 32'd8);

    // Back-to-back 8'hB5 then 8'h5A with din_valid held.
    clear_rec();
    rdy_cnt = 0;
    din[0] = 8'hB5; dv[0] = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      rdy_cnt += int'(rdy_w[0]);
      tick();
      if (i == 0) din[0] = 8'h5A;
      if (i == 8) dv[0] = 1'b0;
    end
    repeat (4) tick();
    check("b2b_count", rec[0].size(), 32'd16);
    check("b2b_stream", rec_vec(0), 32'h0000_B55A);
    check("b2b_ready_cycles", rdy_cnt, 32'd3);
    check("b2b_done_count", done_pos[0].size(), 32'd2);
    if (done_pos[0].size() == 2) begin
      check("b2b_done0", done_pos[0][0], 32'd8);
      check("b2b_done1", done_pos[0][1], 32'd16);
    end

    // 1010 detector over the captured stream, including the boundary-straddling hit.
    for (int i = 3; i < rec[0].size(); i++)
      if ({rec[0][i-3], rec[0][i-2], rec[0][i-1], rec[0][i]} == 4'b1010) hits.push_back(i);
    check("det_hits", hits.size(), 32'd4);
    for (int i = 0; i < 4 && i < hits.size(); i++)
      check($sformatf("det_hit%0d", i), hits[i], exp_hits[i]);

    // Busy rejection: 8'h00 offered during 8'hF0, loaded only on its last-bit edge.
    clear_rec();
    rdy_cnt = 0;
    din[0] = 8'hF0; dv[0] = 1'b1;
    tick();
    din[0] = 8'h00;
    repeat (7) begin
      @(negedge clk);
      rdy_cnt += int'(rdy_w[0]);
      tick();
    end
    tick();
    dv[0] = 1'b0;
    repeat (10) tick();
    check("busy_ready_cycles", rdy_cnt, 32'd0);
    check("busy_count", rec[0].size(), 32'd16);
    check("busy_stream", rec_vec(0), 32'h0000_F000);
    check("busy_done_count", done_pos[0].size(), 32'd2);

    // LSB-first instance with 8'h0A: 0,1,0,1,0,0,0,0.
    clear_rec();
    din[1] = 8'h0A; dv[1] = 1'b1;
    tick();
    dv[1] = 1'b0;
    repeat (10) tick();
    check("lsb_count", rec[1].size(), 32'd8);
    check("lsb_stream", rec_vec(1), 32'h0000_0050);
    check("lsb_done_count", done_pos[1].size(), 32'd1);

    // Reset asserted while bit 3 of 8'hFF is on dout.
    clear_rec();
    din[0] = 8'hFF; dv[0] = 1'b1;
    tick();
    dv[0] = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_dout", 32'(dout_w[0]), 32'd0);
    check("mid_rst_valid", 32'(val_w[0]), 32'd0);
    check("mid_rst_busy", 32'(busy_w[0]), 32'd0);
    check("mid_rst_ready", 32'(rdy_w[0]), 32'd1);
    check("mid_rst_done", 32'(done_w[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (12) tick();
    check("mid_rst_count", rec[0].size(), 32'd4);
    check("mid_rst_done_count", done_pos[0].size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
